// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues fetches to a 1-cycle-latency ROM and buffers
// {pc, inst} pairs in a small FIFO for decode; jumps flush and redirect fetch.
module inst_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          MEM_AW   = 12
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        hold,
   input  logic                        jump_flag,
   input  logic [31:0]                 jump_addr,
   output logic                        imem_rden,
   output logic [MEM_AW-3:0]           imem_addr,
   input  logic [31:0]                 imem_data,
   output logic                        out_vld,
   input  logic                        out_rdy,
   output logic [31:0]                 out_inst,
   output logic [31:0]                 out_pc,
   output logic [$clog2(DEPTH):0]      count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [CW:0] DEPTH_EXT = (CW+1)'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   pc_d1_q, pc_d1_d;
   logic          req_d1_q, req_d1_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   pc_mem_d   [DEPTH];
   logic [31:0]   inst_mem_q [DEPTH];
   logic [31:0]   inst_mem_d [DEPTH];

   logic          credit_s;
   logic          rden_s;
   logic [MEM_AW-3:0] addr_s;
   logic          push_s;
   logic          pop_s;
   logic [31:0]   jump_tgt_s;

   assign jump_tgt_s = jump_addr & 32'hFFFF_FFFC;
   // Credits count the in-flight word, so the FIFO can never be overrun.
   assign credit_s   = ({1'b0, count_q} + {{CW{1'b0}}, req_d1_q}) < DEPTH_EXT;

   always_comb begin
      rden_s = 1'b0;
      addr_s = fetch_pc_q[MEM_AW-1:2];
      if (rst) begin
         rden_s = 1'b0;
      end else if (jump_flag) begin
         rden_s = 1'b1;
         addr_s = jump_addr[MEM_AW-1:2];
      end else if (!hold && credit_s) begin
         rden_s = 1'b1;
      end else begin
         rden_s = 1'b0;
      end
   end

   assign push_s = req_d1_q;
   assign pop_s  = (count_q != {CW{1'b0}}) && out_rdy;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      pc_d1_d    = pc_d1_q;
      req_d1_d   = req_d1_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;
      if (jump_flag) begin
         // A response or pop landing in the jump cycle belongs to the old stream.
         fetch_pc_d = jump_tgt_s + 32'd4;
         pc_d1_d    = jump_tgt_s;
         req_d1_d   = 1'b1;
         rd_ptr_d   = {PW{1'b0}};
         wr_ptr_d   = {PW{1'b0}};
         count_d    = {CW{1'b0}};
      end else begin
         req_d1_d = rden_s;
         if (rden_s) begin
            pc_d1_d    = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
         end else begin
            pc_d1_d    = pc_d1_q;
            fetch_pc_d = fetch_pc_q;
         end
         if (push_s) begin
            pc_mem_d[wr_ptr_q]   = pc_d1_q;
            inst_mem_d[wr_ptr_q] = imem_data;
            wr_ptr_d             = wr_ptr_q + PW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         pc_d1_q    <= 32'h0000_0000;
         req_d1_q   <= 1'b0;
         rd_ptr_q   <= {PW{1'b0}};
         wr_ptr_q   <= {PW{1'b0}};
         count_q    <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= 32'h0000_0000;
            inst_mem_q[i] <= NOP;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         pc_d1_q    <= pc_d1_d;
         req_d1_q   <= req_d1_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= pc_mem_d[i];
            inst_mem_q[i] <= inst_mem_d[i];
         end
      end
   end

   assign imem_rden = rden_s;
   assign imem_addr = addr_s;
   assign count     = count_q;
   assign out_vld   = (count_q != {CW{1'b0}});
   assign out_inst  = out_vld ? inst_mem_q[rd_ptr_q] : NOP;
   assign out_pc    = out_vld ? pc_mem_q[rd_ptr_q]   : 32'h0000_0000;

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
Fetch-side stage between the PC/instruction-memory pair and instruction decode. It generates fetch addresses to a synchronous instruction ROM with 1-cycle read latency and buffers returned words with their PCs in a DEPTH-entry FIFO. It presents them to decode over a valid/ready handshake. Jumps redirect fetch and flush all buffered and in-flight words.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset
MEM_AW, 12, byte-address bits seen by instruction ROM; word address = pc[MEM_AW-1:2]

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
hold  in  1  stall: suppress new fetch requests
jump_flag  in  1  redirect request from execute, single-cycle pulse
jump_addr  in  32  redirect target; bits [1:0] ignored
imem_rden  out  1  ROM read strobe
imem_addr  out  MEM_AW-2  ROM word address
imem_data  in  32  ROM data, valid the cycle after imem_rden
out_vld  out  1  head entry valid
out_rdy  in  1  decode accepts head entry
out_inst  out  32  head instruction
out_pc  out  32  PC of head instruction
count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, count=0, pointers=0, req_d1=0, imem_rden=0, out_vld=0, out_inst=32'h0000_0013 (NOP), out_pc=0.
- State: fetch_pc (32b), FIFO of {pc,inst}, rd/wr pointers (wrap mod DEPTH), req_d1 (request issued last cycle), pc_d1 (its PC).
- Issue (combinational): without jump, imem_rden = !rst && !hold && (count + req_d1 < DEPTH), imem_addr = fetch_pc[MEM_AW-1:2]. On issue, fetch_pc <= fetch_pc+4, modulo 2^32. A same-cycle pop does not free a credit until the next cycle.
- Jump (jump_flag=1 in cycle t): overrides hold and the credit check. imem_rden=1 and imem_addr=jump_addr[MEM_AW-1:2] in cycle t. At the edge ending t: count=0, pointers=0, fetch_pc={jump_addr[31:2],2'b00}+4, pc_d1={jump_addr[31:2],2'b00}, req_d1=1. Any response arriving in t is discarded. A pop in cycle t is accepted but has no further effect. Target word is pushed at end of t+1, so out_vld=1 in t+2.
- Response capture: when req_d1=1 and no jump this cycle, push {pc_d1, imem_data} at the cycle's edge. Push never overflows by construction; overflow is a design error that verification must assert.
- Output: out_vld = (count!=0). out_inst/out_pc are the head entry, combinational from the FIFO. When empty they read NOP/0.
- Pop: out_vld && out_rdy advances rd pointer. Pop when empty is ignored.
- Simultaneous push+pop: count unchanged, both pointers advance. Wrap-around of pointers is transparent.
- hold: affects only new requests. An in-flight response is still captured, and pops continue.
- Steady state with out_rdy=1 and hold=0: one instruction per cycle. First out_vld comes 2 cycles after the first post-reset rden.
- Latency: request cycle t, data at ROM t+1, visible at output t+2.

Test Plan:
- Stream: ROM[i]=i, out_rdy=1, release reset. rden from cycle 0 at addr 0,1,2,… out_vld from cycle 2 with (pc,inst)=(0,0),(4,1),(8,2)… one per cycle, no gaps.
- Backpressure: out_rdy=0 from reset. Exactly 4 rden pulses, then count=4 and rden=0. Set out_rdy=1: outputs pc 0,4,8,12,16… in order, no loss or duplicate, and rden resumes one cycle after the first pop.
- Flush: with 3 entries queued and a request in flight, pulse jump_flag with jump_addr=0x100. imem_addr=0x40 same cycle; count=0 next cycle; next out is (0x100, ROM[0x40]) at t+2; no old entry appears.
- Misaligned/hold jump: jump_addr=0x103 with hold=1 -> rden=1, addr=0x40, out_pc=0x100; afterwards with hold still 1 no further rden; hold=0 resumes at 0x104.
- Hold: hold=1 for 5 cycles mid-stream -> no rden; the in-flight word is captured; queue drains to 0; out_vld drops; no PC skipped after release.
- Async reset mid-stream: assert rst between edges -> out_vld, imem_rden, count go 0 immediately. After release, fetch restarts at RESET_PC.
